// File: rtl/d_grf_bypass.sv
// 32 x 32-bit general register file with two combinational read ports, one
// write port, internal W->D bypass and $0 hardwired to zero. Optional write
// log enabled by defining GRF_DISPLAY_EN.
module d_grf_bypass #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] D_A1,
    input  logic [ADDR_W-1:0] D_A2,
    output logic [DATA_W-1:0] D_RD1,
    output logic [DATA_W-1:0] D_RD2,
    input  logic              W_RegWrite,
    input  logic [ADDR_W-1:0] W_A3,
    input  logic [DATA_W-1:0] W_RegWriteData,
    input  logic [31:0]       W_PC
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              commit_s;

    // A write commits only out of reset and never to $0; the same condition
    // qualifies the bypass so reads during reset stay at zero.
    assign commit_s = reset && W_RegWrite && (W_A3 != {ADDR_W{1'b0}});

    // Resolve one read port: $0, then same-cycle write, then stored value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              commit,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] rd;
        if (addr == {ADDR_W{1'b0}}) begin
            rd = {DATA_W{1'b0}};
        end else if (commit && (waddr == addr)) begin
            rd = wdata;
        end else begin
            rd = stored;
        end
        return rd;
    endfunction

    // Next-state of the register array: only the addressed entry changes.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_s && (W_A3 == ADDR_W'(i))) begin
                regs_d[i] = W_RegWriteData;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        regs_d[0] = {DATA_W{1'b0}};
    end

    // Register array storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Zero-latency read ports; D-stage sees this cycle's W-stage write.
    always_comb begin
        D_RD1 = read_port(D_A1, commit_s, W_A3, W_RegWriteData, regs_q[D_A1]);
        D_RD2 = read_port(D_A2, commit_s, W_A3, W_RegWriteData, regs_q[D_A2]);
    end

`ifdef GRF_DISPLAY_EN
    // Simulation log of every committed write, printed at the clock edge.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            $display("%d@%h: $%d <= %h", $time, W_PC, W_A3, W_RegWriteData);
        end
    end
`else
    logic unused_pc_s;
    assign unused_pc_s = ^W_PC;
`endif

endmodule

// File: tb/tb_d_grf_bypass.sv
// Self-checking bench for d_grf_bypass: directed cases plus randomized
// traffic checked against an array-based reference model.
module tb_d_grf_bypass;

    logic        clk;
    logic        reset;
    logic [4:0]  D_A1, D_A2, W_A3;
    logic [31:0] D_RD1, D_RD2, W_RegWriteData, W_PC;
    logic        W_RegWrite;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [31:0] model [32];

    d_grf_bypass dut (
        .clk(clk), .reset(reset),
        .D_A1(D_A1), .D_A2(D_A2), .D_RD1(D_RD1), .D_RD2(D_RD2),
        .W_RegWrite(W_RegWrite), .W_A3(W_A3),
        .W_RegWriteData(W_RegWriteData), .W_PC(W_PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected read value straight from the architectural rules.
    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (reset !== 1'b1) return 32'd0;
        if (W_RegWrite && W_A3 == a) return W_RegWriteData;
        return model[a];
    endfunction

    task automatic check_ports(input string tag);
        #2;
        chk({tag, "_rd1"}, D_RD1, expect_rd(D_A1));
        chk({tag, "_rd2"}, D_RD2, expect_rd(D_A2));
    endtask

    // Advance one clock; model commits exactly as the write rule says.
    task automatic clock_step();
        @(posedge clk);
        if (reset === 1'b1 && W_RegWrite && W_A3 != 5'd0) model[W_A3] = W_RegWriteData;
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        W_RegWrite = we; W_A3 = wa; W_RegWriteData = wd; D_A1 = a1; D_A2 = a2;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        reset = 1'b0; W_PC = 32'h0000_3000;
        drive(1'b1, 5'd4, 32'hCAFE_0004, 5'd4, 5'd9);
        @(negedge clk);
        check_ports("in_reset_bypass_blocked");
        chk("in_reset_rd1_zero", D_RD1, 32'd0);
        clock_step();
        reset = 1'b1;
        drive(1'b0, 5'd4, 32'd0, 5'd4, 5'd0);
        check_ports("after_reset_write_lost");

        // Fill regs 1..31 with nonzero data, checking the bypass each cycle.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), ($urandom | 32'h1), 5'(i), 5'(i - 1));
            check_ports("fill_bypass");
            clock_step();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i += 2) begin
            D_A1 = 5'(i); D_A2 = 5'(i + 1);
            check_ports("fill_readback");
        end

        // Asynchronous reset between edges clears every register at once.
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int i = 0; i < 32; i += 2) begin
            D_A1 = 5'(i); D_A2 = 5'(i + 1);
            #1;
            chk("async_clear_rd1", D_RD1, 32'd0);
            chk("async_clear_rd2", D_RD2, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Basic write then read.
        drive(1'b1, 5'd5, 32'h1234_5678, 5'd1, 5'd2);
        clock_step();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        check_ports("basic");
        chk("basic_const", D_RD1, 32'h1234_5678);

        // Same-cycle bypass on both ports, then stored value.
        drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd8);
        check_ports("bypass");
        chk("bypass_const1", D_RD1, 32'hDEAD_BEEF);
        chk("bypass_const2", D_RD2, 32'hDEAD_BEEF);
        clock_step();
        drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd5);
        check_ports("bypass_stored");

        // $0 protection before and after the edge.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check_ports("zero_before");
        chk("zero_before_const", D_RD1, 32'd0);
        clock_step();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check_ports("zero_after");

        // Disabled write leaves regs[3]=7.
        drive(1'b1, 5'd3, 32'd7, 5'd0, 5'd0);
        clock_step();
        drive(1'b0, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd3);
        check_ports("disabled_before");
        chk("disabled_before_const", D_RD2, 32'd7);
        clock_step();
        check_ports("disabled_after");
        chk("disabled_after_const", D_RD2, 32'd7);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom));
            check_ports("random");
            clock_step();
        end

        // Reset falling with a write pending: the write is lost.
        drive(1'b1, 5'd7, 32'h7777_7777, 5'd7, 5'd3);
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        check_ports("reset_mid_pending");
        clock_step();
        reset = 1'b1;
        drive(1'b0, 5'd7, 32'd0, 5'd7, 5'd3);
        check_ports("reset_mid_lost");
        drive(1'b1, 5'd7, 32'h0BAD_F00D, 5'd1, 5'd2);
        clock_step();
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        check_ports("first_write_after_reset");
        chk("first_write_const", D_RD1, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
